// File: rtl/itl_pair_serializer.sv
`default_nettype none
// ============================================================================
// Module   : itl_pair_serializer
// Purpose  : Buffers 4-pair quads from the RX turbo interleaver in a small
//            FIFO and emits them one 2-bit pair per cycle to the turbo
//            decoder under valid/ready, framed by sop/eop per PB size.
// Revision : 1.0 - initial release
// ============================================================================
module itl_pair_serializer #(
    parameter int FIFO_DEPTH = 8,
    parameter int PTR_W      = 3
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [1:0] pb_size,
    input  logic       start,
    input  logic [1:0] in_quad0,
    input  logic [1:0] in_quad1,
    input  logic [1:0] in_quad2,
    input  logic [1:0] in_quad3,
    input  logic       in_vld,
    output logic       in_rdy,
    output logic [1:0] dout,
    output logic       dout_vld,
    input  logic       dout_rdy,
    output logic       dout_sop,
    output logic       dout_eop,
    output logic       busy,
    output logic       err_len,
    output logic       err_abort
);

    localparam logic [0:0]     c_ST_IDLE  = 1'b0;
    localparam logic [0:0]     c_ST_RUN   = 1'b1;
    localparam logic [PTR_W:0] c_PTR_ONE  = (PTR_W+1)'(1);

    logic [0:0]     r_state;
    logic [7:0]     r_mem [FIFO_DEPTH];
    logic [PTR_W:0] r_wr_ptr;
    logic [PTR_W:0] r_rd_ptr;
    logic [11:0]    r_frame_len;
    logic [11:0]    r_pair_cnt;
    logic [9:0]     r_wr_quads;
    logic [1:0]     r_lane;
    logic           r_err_len;
    logic           r_err_abort;

    logic           w_run;
    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_hs;
    logic           w_pop;
    logic           w_eop;
    logic           w_eop_hs;
    logic [7:0]     w_head;
    logic [1:0]     w_head_pair;
    logic [11:0]    w_new_len;

    // Pointer MSB is the wrap bit: equal low bits with differing wrap means full
    assign w_run    = (r_state == c_ST_RUN);
    assign w_full   = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                      (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_empty  = (r_wr_ptr == r_rd_ptr);

    assign in_rdy   = w_run && !w_full && (r_wr_quads < r_frame_len[11:2]);
    assign w_push   = in_vld && in_rdy;

    assign dout_vld = w_run && !w_empty;
    assign w_hs     = dout_vld && dout_rdy;
    assign w_pop    = w_hs && (r_lane == 2'd3);
    assign w_eop    = dout_vld && (r_pair_cnt == (r_frame_len - 12'd1));
    assign w_eop_hs = w_hs && w_eop;

    assign w_head   = r_mem[r_rd_ptr[PTR_W-1:0]];

    // Select the current lane of the head quad; lane 0 leaves first
    always_comb begin
        w_head_pair = w_head[1:0];
        case (r_lane)
            2'd0:    w_head_pair = w_head[1:0];
            2'd1:    w_head_pair = w_head[3:2];
            2'd2:    w_head_pair = w_head[5:4];
            default: w_head_pair = w_head[7:6];
        endcase
    end

    // Frame length in pairs for the requested PB size (0 marks illegal)
    always_comb begin
        w_new_len = 12'd0;
        case (pb_size)
            2'd0:    w_new_len = 12'd64;
            2'd1:    w_new_len = 12'd544;
            2'd2:    w_new_len = 12'd2080;
            default: w_new_len = 12'd0;
        endcase
    end

    // Outputs are forced to 0 while nothing valid is presented
    assign dout      = dout_vld ? w_head_pair : 2'b00;
    assign dout_sop  = dout_vld && (r_pair_cnt == 12'd0);
    assign dout_eop  = w_eop;
    assign busy      = w_run;
    assign err_len   = r_err_len;
    assign err_abort = r_err_abort;

    // Quad storage; lane 0 sits in the low bits
    always_ff @(posedge clk) begin
        if (w_push && !start) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= {in_quad3, in_quad2, in_quad1, in_quad0};
        end
    end

    // Control: start always re-arms (flushing any frame in flight), otherwise
    // advance pointers and counters on push/handshake and leave RUN after eop
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= c_ST_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_frame_len <= 12'd0;
            r_pair_cnt  <= 12'd0;
            r_wr_quads  <= 10'd0;
            r_lane      <= 2'd0;
            r_err_len   <= 1'b0;
            r_err_abort <= 1'b0;
        end else begin
            // A start that coincides with the eop handshake is a clean hand-over
            r_err_abort <= start && w_run && !w_eop_hs;
            if (start) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_pair_cnt <= 12'd0;
                r_wr_quads <= 10'd0;
                r_lane     <= 2'd0;
                if (pb_size != 2'd3) begin
                    r_state     <= c_ST_RUN;
                    r_frame_len <= w_new_len;
                    r_err_len   <= 1'b0;
                end else begin
                    r_state   <= c_ST_IDLE;
                    r_err_len <= 1'b1;
                end
            end else begin
                if (w_push) begin
                    r_wr_ptr   <= r_wr_ptr + c_PTR_ONE;
                    r_wr_quads <= r_wr_quads + 10'd1;
                end
                if (w_hs) begin
                    r_pair_cnt <= r_pair_cnt + 12'd1;
                    r_lane     <= r_lane + 2'd1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                end
                if (w_eop_hs) begin
                    r_state <= c_ST_IDLE;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_itl_pair_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_itl_pair_serializer
// Purpose  : Scoreboard bench for itl_pair_serializer. The stimulus process
//            pushes expected {sop,eop,pair} entries as quads are accepted;
//            a monitor pops and compares on every output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_itl_pair_serializer;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [1:0] pb_size;
    logic       start;
    logic [1:0] in_quad0, in_quad1, in_quad2, in_quad3;
    logic       in_vld;
    logic       in_rdy;
    logic [1:0] dout;
    logic       dout_vld;
    logic       dout_rdy;
    logic       dout_sop, dout_eop, busy, err_len, err_abort;

    itl_pair_serializer #(.FIFO_DEPTH(8), .PTR_W(3)) dut (
        .clk(clk), .n_rst(n_rst), .pb_size(pb_size), .start(start),
        .in_quad0(in_quad0), .in_quad1(in_quad1), .in_quad2(in_quad2), .in_quad3(in_quad3),
        .in_vld(in_vld), .in_rdy(in_rdy), .dout(dout), .dout_vld(dout_vld),
        .dout_rdy(dout_rdy), .dout_sop(dout_sop), .dout_eop(dout_eop), .busy(busy),
        .err_len(err_len), .err_abort(err_abort)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] sb[$];          // {sop, eop, pair}
    int         sent;           // quads accepted in current frame
    int         fn;             // expected frame length in pairs
    bit         feed;           // a legal frame is active on the stimulus side
    bit         acc;            // last offered quad was accepted
    bit         rnd_rdy;
    bit         gaps;
    int         frame_hs = 0;   // written by monitor only
    int         eop_cnt  = 0;   // written by monitor only

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int frame_pairs(input logic [1:0] sz);
        case (sz)
            2'd0:    return 64;
            2'd1:    return 544;
            2'd2:    return 2080;
            default: return 0;
        endcase
    endfunction

    // Reference pair value for pair index p; low bits make the 4 lanes distinct
    function automatic logic [1:0] pat(input int p);
        logic [11:0] v;
        v = p[11:0];
        return v[1:0] ^ v[3:2] ^ v[7:6] ^ v[10:9];
    endfunction

    // One stimulus cycle: optional start, in_rdy check, quad offer, scoreboard push
    task automatic step(input bit st, input logic [1:0] sz);
        int occ;
        int p;
        @(negedge clk);
        if (st) begin
            start   = 1'b1;
            pb_size = sz;
            in_vld  = 1'b0;
            acc     = 1'b0;
            sent    = 0;
            sb.delete();
            fn      = frame_pairs(sz);
            feed    = (sz != 2'd3);
        end else begin
            start = 1'b0;
            occ = sent - frame_hs / 4;
            chk("in_rdy", int'(in_rdy), int'(feed && occ < 8 && sent < fn / 4));
            if (occ > 8) chk("occupancy", occ, 8);
            if (!in_vld || acc) begin
                if (feed && sent < fn / 4 && (!gaps || $urandom_range(0, 2) != 0)) begin
                    in_vld   = 1'b1;
                    in_quad0 = pat(4 * sent + 0);
                    in_quad1 = pat(4 * sent + 1);
                    in_quad2 = pat(4 * sent + 2);
                    in_quad3 = pat(4 * sent + 3);
                end else begin
                    in_vld = 1'b0;
                end
            end
            acc = in_vld && in_rdy;
            if (acc) begin
                for (int l = 0; l < 4; l++) begin
                    p = 4 * sent + l;
                    sb.push_back({(p == 0), (p == fn - 1), pat(p)});
                end
                sent++;
            end
        end
        dout_rdy = rnd_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
    endtask

    task automatic run_to_eop(input string tag);
        int target;
        int k;
        target = eop_cnt + 1;
        for (k = 0; k < 10000; k++) begin
            step(1'b0, 2'd0);
            if (eop_cnt >= target) break;
        end
        if (k >= 10000) chk({tag, "_timeout"}, k, 0);
        chk({tag, "_busy_after_eop"}, int'(busy), 0);
        chk({tag, "_eop_count"}, eop_cnt, target);
        chk({tag, "_pairs"}, frame_hs, fn);
        chk({tag, "_quads"}, sent, fn / 4);
        chk({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    task automatic run_to_pair(input int n, input string tag);
        int k;
        for (k = 0; k < 5000; k++) begin
            step(1'b0, 2'd0);
            if (frame_hs >= n) break;
        end
        if (k >= 5000) chk({tag, "_timeout"}, k, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_rdy"}, int'(in_rdy), 0);
        chk({tag, "_dout"}, int'(dout), 0);
        chk({tag, "_dout_vld"}, int'(dout_vld), 0);
        chk({tag, "_sop"}, int'(dout_sop), 0);
        chk({tag, "_eop"}, int'(dout_eop), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_err_len"}, int'(err_len), 0);
        chk({tag, "_err_abort"}, int'(err_abort), 0);
    endtask

    // Monitor: compare every handshake against the scoreboard; check stall hold
    initial begin
        logic [3:0] e;
        bit         stall;
        logic [1:0] held;
        stall = 1'b0;
        held  = 2'd0;
        forever begin
            @(negedge clk);
            #1;
            if (!n_rst || start) begin
                frame_hs = 0;
                stall    = 1'b0;
            end else begin
                if (stall) chk("hold", int'({dout_vld, dout}), int'({1'b1, held}));
                if (dout_vld && dout_rdy) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_pair", int'(dout), -1);
                    end else begin
                        e = sb.pop_front();
                        chk("pair_sop_eop_dout", int'({dout_sop, dout_eop, dout}), int'(e));
                    end
                    frame_hs++;
                    if (dout_eop) eop_cnt++;
                end
                stall = dout_vld && !dout_rdy;
                held  = dout;
            end
        end
    end

    initial begin
        n_rst = 1'b0; start = 1'b0; pb_size = 2'd0; in_vld = 1'b0; dout_rdy = 1'b0;
        in_quad0 = 2'd0; in_quad1 = 2'd0; in_quad2 = 2'd0; in_quad3 = 2'd0;
        sent = 0; fn = 0; feed = 1'b0; acc = 1'b0; rnd_rdy = 1'b0; gaps = 1'b0;
        repeat (3) @(negedge clk);
        #1 chk_all_zero("reset");
        n_rst = 1'b1;

        // Quad offered while IDLE must not be accepted
        @(negedge clk);
        in_vld = 1'b1; in_quad0 = 2'd3;
        #1 chk("idle_in_rdy", int'(in_rdy), 0);
        in_vld = 1'b0;
        step(1'b0, 2'd0);

        // 1: PB16 full rate
        step(1'b1, 2'd0);
        run_to_eop("pb16");

        // 2: PB136 random sink stalls
        rnd_rdy = 1'b1;
        step(1'b1, 2'd1);
        run_to_eop("pb136");

        // 3: PB520 with source gaps
        gaps = 1'b1;
        step(1'b1, 2'd2);
        run_to_eop("pb520");
        gaps = 1'b0;

        // 4: abort PB136 after 100 pairs, then a fresh frame
        step(1'b1, 2'd1);
        run_to_pair(100, "abort_wait");
        step(1'b1, 2'd1);
        step(1'b0, 2'd0);
        chk("abort_pulse", int'(err_abort), 1);
        chk("abort_flush_vld", int'(dout_vld), 0);
        step(1'b0, 2'd0);
        chk("abort_pulse_end", int'(err_abort), 0);
        run_to_eop("after_abort");
        rnd_rdy = 1'b0;

        // 5: illegal size, then legal start clears err_len
        step(1'b1, 2'd3);
        step(1'b0, 2'd0);
        chk("err_len_set", int'(err_len), 1);
        chk("err_len_busy", int'(busy), 0);
        chk("err_len_abort", int'(err_abort), 0);
        step(1'b1, 2'd0);
        step(1'b0, 2'd0);
        chk("err_len_clear", int'(err_len), 0);
        run_to_eop("after_err_len");

        // 6: reset in the middle of a PB16 frame
        step(1'b1, 2'd0);
        run_to_pair(30, "rst_wait");
        n_rst = 1'b0;
        in_vld = 1'b0; acc = 1'b0; feed = 1'b0; sent = 0; fn = 0;
        sb.delete();
        #1 chk_all_zero("midframe_reset");
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (4) step(1'b0, 2'd0);
        chk("post_reset_busy", int'(busy), 0);
        chk("post_reset_in_rdy", int'(in_rdy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
